bpeb_term_sched: RTL and testbench

- Term-serial scheduler for the Booth-pair essential-bit datapath.
- Accepts one 16-bit activation plus an approximation level n_ap, and forms the 8 radix-4 Booth triplets.
- Drops non-essential triplets (000/111) and triplets below n_ap.
- Streams the remaining essential terms LSB-first, one per handshake, to the downstream shift-add PE. Zero-term operands cost one cycle.

---
 rtl/bpeb_term_sched.sv | 148 ++++++++++++++
 tb/tb_bpeb_term_sched.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpeb_term_sched.sv
// Booth-pair essential-bit term scheduler; BPEB_TERM_STATS_EN adds saturating term/operand counters.
// Latency: 1 + N cycles per operand (2 if no terms); term_* held stable while term_ready is low.
module bpeb_term_sched #(
    parameter int NUM_TERMS = 8,
    parameter int NAP_MAX   = 6,
    parameter int DATA_W    = 2*NUM_TERMS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_act,
    input  logic [3:0]        in_nap,
    output logic              term_valid,
    input  logic              term_ready,
    output logic              term_sign,
    output logic              term_dbl,
    output logic [3:0]        term_shift,
    output logic              term_last,
    output logic              act_done,
    output logic [3:0]        etc_out,
    output logic              busy
`ifdef BPEB_TERM_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [15:0]       stat_terms,
    output logic [15:0]       stat_ops
`endif
);
    localparam int IDX_W = $clog2(NUM_TERMS);

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_ZERO} state_t;

    state_t               r_state;
    logic [NUM_TERMS-1:0] r_mask;
    logic [DATA_W-1:0]    r_act;
    logic [3:0]           r_etc;

    logic [DATA_W:0]      w_in_ext;
    logic [DATA_W:0]      w_lat_ext;
    logic [3:0]           w_nap_eff;
    logic [NUM_TERMS-1:0] w_new_mask;
    logic [3:0]           w_new_cnt;
    logic [3:0]           w_rem_cnt;
    logic [IDX_W-1:0]     w_idx;
    logic [2:0]           w_trip;
    logic                 w_emit;
    logic                 w_last;
    logic                 w_hs;

    // Bit -1 of the activation is an implicit zero appended below the LSB.
    assign w_in_ext  = {in_act, 1'b0};
    assign w_lat_ext = {r_act, 1'b0};
    assign w_nap_eff = (in_nap > 4'(NAP_MAX)) ? 4'(NAP_MAX) : in_nap;

    always_comb begin
        w_new_mask = '0;
        w_new_cnt  = '0;
        for (int i = 0; i < NUM_TERMS; i++) begin
            w_new_mask[i] = (w_in_ext[2*i +: 3] != 3'b000) &&
                            (w_in_ext[2*i +: 3] != 3'b111) &&
                            (i >= int'(w_nap_eff));
            w_new_cnt = w_new_cnt + 4'(w_new_mask[i]);
        end
    end

    // Scanning downward leaves the lowest set bit in w_idx.
    always_comb begin
        w_idx     = '0;
        w_rem_cnt = '0;
        for (int i = NUM_TERMS-1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_idx = IDX_W'(i);
            end
            w_rem_cnt = w_rem_cnt + 4'(r_mask[i]);
        end
    end

    assign w_trip = w_lat_ext[{w_idx, 1'b0} +: 3];
    assign w_emit = (r_state == S_EMIT);
    assign w_last = (w_rem_cnt == 4'd1);
    assign w_hs   = w_emit && term_ready;

    assign in_ready   = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign term_valid = w_emit;
    assign term_sign  = w_emit && w_trip[2];
    assign term_dbl   = w_emit && ((w_trip == 3'b011) || (w_trip == 3'b100));
    assign term_shift = w_emit ? 4'({w_idx, 1'b0}) : 4'd0;
    assign term_last  = w_emit && w_last;
    assign act_done   = (r_state == S_ZERO) || (w_hs && w_last);
    assign etc_out    = r_etc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
            r_act   <= '0;
            r_etc   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_act   <= in_act;
                        r_mask  <= w_new_mask;
                        r_etc   <= w_new_cnt;
                        r_state <= (w_new_mask == '0) ? S_ZERO : S_EMIT;
                    end
                end
                S_ZERO: r_state <= S_IDLE;
                S_EMIT: begin
                    if (term_ready) begin
                        r_mask[w_idx] <= 1'b0;
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef BPEB_TERM_STATS_EN
    logic [15:0] r_stat_terms;
    logic [15:0] r_stat_ops;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_terms <= '0;
            r_stat_ops   <= '0;
        end else if (stat_clr) begin
            r_stat_terms <= '0;
            r_stat_ops   <= '0;
        end else begin
            if (w_hs && (r_stat_terms != 16'hFFFF)) begin
                r_stat_terms <= r_stat_terms + 16'd1;
            end
            if (act_done && (r_stat_ops != 16'hFFFF)) begin
                r_stat_ops <= r_stat_ops + 16'd1;
            end
        end
    end

    assign stat_terms = r_stat_terms;
    assign stat_ops   = r_stat_ops;
`endif
endmodule

// File: tb/tb_bpeb_term_sched.sv
// Scoreboard bench for bpeb_term_sched: a Booth-digit reference model feeds expected
// terms into a queue that a negedge monitor pops whenever the DUT hands off a term or done.
module tb_bpeb_term_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_act;
    logic [3:0]  in_nap;
    logic        term_valid;
    logic        term_ready;
    logic        term_sign;
    logic        term_dbl;
    logic [3:0]  term_shift;
    logic        term_last;
    logic        act_done;
    logic [3:0]  etc_out;
    logic        busy;
`ifdef BPEB_TERM_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_terms;
    logic [15:0] stat_ops;
`endif

    always #5 clk = ~clk;

    bpeb_term_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_act     (in_act),
        .in_nap     (in_nap),
        .term_valid (term_valid),
        .term_ready (term_ready),
        .term_sign  (term_sign),
        .term_dbl   (term_dbl),
        .term_shift (term_shift),
        .term_last  (term_last),
        .act_done   (act_done),
        .etc_out    (etc_out),
        .busy       (busy)
`ifdef BPEB_TERM_STATS_EN
        ,
        .stat_clr   (stat_clr),
        .stat_terms (stat_terms),
        .stat_ops   (stat_ops)
`endif
    );

    typedef struct {
        bit zero;
        bit sign;
        bit dbl;
        int shift;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   etc_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   hs_count = 0;
    bit   rnd_rdy  = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
    endtask

    // Reference: Booth digit d_i = -2*a[2i+1] + a[2i] + a[2i-1]; keep nonzero digits at i >= min(nap,6).
    task automatic model_push(input logic [15:0] a, input logic [3:0] n);
        exp_t        loc[$];
        exp_t        e;
        logic [16:0] ext;
        int          nap_eff;
        int          d;
        nap_eff = (int'(n) > 6) ? 6 : int'(n);
        ext = {a, 1'b0};
        for (int i = 0; i < 8; i++) begin
            d = -2 * int'(ext[2*i+2]) + int'(ext[2*i+1]) + int'(ext[2*i]);
            if (d != 0 && i >= nap_eff) begin
                e.zero  = 1'b0;
                e.sign  = (d < 0);
                e.dbl   = (d == 2 || d == -2);
                e.shift = 2 * i;
                e.last  = 1'b0;
                loc.push_back(e);
            end
        end
        etc_q.push_back(loc.size());
        if (loc.size() == 0) begin
            e.zero = 1'b1; e.sign = 1'b0; e.dbl = 1'b0; e.shift = 0; e.last = 1'b1;
            exp_q.push_back(e);
        end else begin
            loc[loc.size()-1].last = 1'b1;
            foreach (loc[k]) exp_q.push_back(loc[k]);
        end
    endtask

    // Offers one operand; while the DUT is busy, random in_valid noise is driven and must be ignored.
    task automatic send(input logic [15:0] a, input logic [3:0] n);
        int guard = 0;
        @(posedge clk); #1;
        while (!in_ready && guard < 200) begin
            in_valid = 1'($urandom % 2);
            in_act   = 16'($urandom);
            in_nap   = 4'($urandom);
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) fail_now("in_ready_timeout");
        in_valid = 1'b1;
        in_act   = a;
        in_nap   = n;
        model_push(a, n);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_act   = 16'($urandom);
    endtask

    task automatic wait_idle(input string name, input int expc);
        int c = 0;
        while (!in_ready && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk(name, c, expc);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_term_valid"}, term_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_act_done"}, act_done, 0);
        chk({tag, "_etc_out"}, etc_out, 0);
        chk({tag, "_fields"}, int'({term_sign, term_dbl, term_shift, term_last}), 0);
    endtask

    // Monitor / scoreboard.
    initial begin
        bit         pend;
        logic [6:0] saved;
        exp_t       e;
        int         ee;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
                exp_q.delete();
                etc_q.delete();
            end else begin
                if (pend) begin
                    chk("hold_valid", term_valid, 1);
                    chk("hold_fields", int'({term_sign, term_dbl, term_shift, term_last}), int'(saved));
                    pend = 1'b0;
                end
                if (term_valid && term_ready) begin
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_term");
                    end else begin
                        e = exp_q.pop_front();
                        chk("term_kind", 0, int'(e.zero));
                        chk("term_sign", term_sign, int'(e.sign));
                        chk("term_dbl", term_dbl, int'(e.dbl));
                        chk("term_shift", term_shift, e.shift);
                        chk("term_last", term_last, int'(e.last));
                        chk("done_with_last", act_done, int'(e.last));
                        if (e.last) begin
                            if (etc_q.size() == 0) fail_now("etc_queue_empty");
                            else begin
                                ee = etc_q.pop_front();
                                chk("etc_out", etc_out, ee);
                            end
                        end
                    end
                end else if (term_valid) begin
                    pend  = 1'b1;
                    saved = {term_sign, term_dbl, term_shift, term_last};
                    chk("no_done_in_stall", act_done, 0);
                end else begin
                    chk("idle_fields", int'({term_sign, term_dbl, term_shift, term_last}), 0);
                    if (act_done) begin
                        if (exp_q.size() == 0) fail_now("unexpected_done");
                        else begin
                            e = exp_q.pop_front();
                            chk("zero_kind", 1, int'(e.zero));
                            if (etc_q.size() == 0) fail_now("etc_queue_empty");
                            else begin
                                ee = etc_q.pop_front();
                                chk("etc_out_zero", etc_out, ee);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_rdy) term_ready = (($urandom % 4) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          g;
        logic [15:0] a;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_act     = '0;
        in_nap     = '0;
        term_ready = 1'b1;
`ifdef BPEB_TERM_STATS_EN
        stat_clr   = 1'b0;
`endif
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        send(16'h0000, 4'd0);  wait_idle("lat_zero", 1);
        send(16'h0001, 4'd0);  wait_idle("lat_one", 1);
        send(16'h7FFF, 4'd0);  wait_idle("lat_7fff", 2);
        send(16'h5555, 4'd0);  wait_idle("lat_5555_n0", 8);
        send(16'h5555, 4'd3);  wait_idle("lat_5555_n3", 5);
        send(16'h5555, 4'd9);  wait_idle("lat_5555_n9", 2);

        // Stall on the second term of 0x5555.
        send(16'h5555, 4'd0);
        g = 0;
        while (!(term_valid && term_shift == 4'd2) && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 20) fail_now("stall_reach_term2");
        term_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_valid", term_valid, 1);
            chk("stall_sign", term_sign, 0);
            chk("stall_dbl", term_dbl, 0);
            chk("stall_shift", term_shift, 2);
            chk("stall_last", term_last, 0);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_act_done", act_done, 0);
        end
        term_ready = 1'b1;
        wait_idle("stall_lat", 7);

        // Asynchronous reset during the 4th term.
        send(16'h5555, 4'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_valid", term_valid, 1);
        chk("pre_rst_shift", term_shift, 6);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(16'h0001, 4'd0);  wait_idle("post_rst_lat", 1);

        // Randomized operands with random downstream backpressure.
        rnd_rdy = 1'b1;
        repeat (80) begin
            case ($urandom % 5)
                0:       a = 16'h0000;
                1:       a = 16'hFFFF;
                2:       a = 16'($urandom) & 16'($urandom);
                default: a = 16'($urandom);
            endcase
            send(a, 4'($urandom % 16));
            repeat ($urandom % 3) begin
                @(posedge clk); #1;
            end
        end
        rnd_rdy = 1'b0;
        @(posedge clk); #1;
        term_ready = 1'b1;
        g = 0;
        while ((exp_q.size() != 0 || !in_ready) && g < 500) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 500) fail_now("drain_timeout");
        chk("etc_queue_drained", etc_q.size(), 0);
        if (hs_count == 0) fail_now("no_handshakes_seen");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
